overlay_bit_fetch: RTL and testbench

Upstream stage of the overlay bit repeater in the HDMI overlay path. Tracks the raster position of the incoming video stream, decides whether each active pixel falls inside the overlay window, and drives the address of the 1-bit overlay bitmap ROM. It returns the ROM bit aligned with a delayed copy of the pixel and sync signals. Its `ovlBit` and `pixOut` outputs feed the repeater's `dataIn` and `ppeIN` directly.

---
 rtl/overlay_bit_fetch.sv | 135 +++++++++++++
 tb/tb_overlay_bit_fetch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/overlay_bit_fetch.sv
// Overlay bitmap fetch: tracks raster position, decides window hits, drives the
// 1-bit ROM address and returns the ROM bit aligned with the delayed video.
module overlay_bit_fetch #(
    parameter int OVL_W   = 128,
    parameter int OVL_H   = 32,
    parameter int ROM_AW  = 12,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              deIn,
    input  logic              hsyncIn,
    input  logic              vsyncIn,
    input  logic [23:0]       pixIn,
    input  logic [11:0]       ovlX,
    input  logic [11:0]       ovlY,
    input  logic              romData,
    output logic [ROM_AW-1:0] romAddr,
    output logic              romEn,
    output logic              deOut,
    output logic              hsyncOut,
    output logic              vsyncOut,
    output logic [23:0]       pixOut,
    output logic              ovlBit
);

    logic              de_prev_q, de_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic [11:0]       x_cnt_q, x_cnt_d;
    logic [11:0]       y_cnt_q, y_cnt_d;
    logic [11:0]       win_x_q, win_x_d;
    logic [11:0]       win_y_q, win_y_d;
    logic [ROM_AW-1:0] row_base_q, row_base_d;
    logic              frame_valid_q, frame_valid_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d;
    // Video bundle is {vsync, hsync, de, pix}; index 0 is stage 0, index ROM_LAT is the output.
    logic [26:0]       vid_dly_q [0:ROM_LAT];
    logic [26:0]       vid_dly_d [0:ROM_LAT];
    logic              hit_dly_q [0:ROM_LAT];
    logic              hit_dly_d [0:ROM_LAT];

    logic vs_rise;
    logic de_fall;
    logic x_in;
    logic y_in;
    logic hit;

    assign vs_rise = vsyncIn & ~vs_prev_q;
    assign de_fall = ~deIn & de_prev_q;
    // 13-bit compares keep a window that crosses column/line 4095 from wrapping.
    assign x_in = ({1'b0, x_cnt_q} >= {1'b0, win_x_q}) &&
                  ({1'b0, x_cnt_q} <  ({1'b0, win_x_q} + 13'(OVL_W)));
    assign y_in = ({1'b0, y_cnt_q} >= {1'b0, win_y_q}) &&
                  ({1'b0, y_cnt_q} <  ({1'b0, win_y_q} + 13'(OVL_H)));
    assign hit  = frame_valid_q & deIn & x_in & y_in;

    always_comb begin
        de_prev_d     = deIn;
        vs_prev_d     = vsyncIn;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        win_x_d       = win_x_q;
        win_y_d       = win_y_q;
        row_base_d    = row_base_q;
        frame_valid_d = frame_valid_q;

        if (vs_rise) begin
            x_cnt_d       = '0;
            y_cnt_d       = '0;
            row_base_d    = '0;
            win_x_d       = ovlX;
            win_y_d       = ovlY;
            frame_valid_d = 1'b1;
        end else if (de_fall) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + 12'd1;
            // Rows advance by the full bitmap width so a right-clipped row keeps its base.
            if (frame_valid_q && y_in) begin
                row_base_d = row_base_q + ROM_AW'(OVL_W);
            end
        end else if (deIn) begin
            x_cnt_d = x_cnt_q + 12'd1;
        end

        rom_addr_d = row_base_q + ROM_AW'(x_cnt_q) - ROM_AW'(win_x_q);
        rom_en_d   = hit;

        vid_dly_d[0] = {vsyncIn, hsyncIn, deIn, pixIn};
        hit_dly_d[0] = hit;
        for (int k = 1; k <= ROM_LAT; k++) begin
            vid_dly_d[k] = vid_dly_q[k-1];
            hit_dly_d[k] = hit_dly_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            win_x_q       <= '0;
            win_y_q       <= '0;
            row_base_q    <= '0;
            frame_valid_q <= 1'b0;
            rom_addr_q    <= '0;
            rom_en_q      <= 1'b0;
            vid_dly_q     <= '{default: '0};
            hit_dly_q     <= '{default: 1'b0};
        end else begin
            de_prev_q     <= de_prev_d;
            vs_prev_q     <= vs_prev_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            win_x_q       <= win_x_d;
            win_y_q       <= win_y_d;
            row_base_q    <= row_base_d;
            frame_valid_q <= frame_valid_d;
            rom_addr_q    <= rom_addr_d;
            rom_en_q      <= rom_en_d;
            vid_dly_q     <= vid_dly_d;
            hit_dly_q     <= hit_dly_d;
        end
    end

    assign romAddr  = rom_addr_q;
    assign romEn    = rom_en_q;
    assign vsyncOut = vid_dly_q[ROM_LAT][26];
    assign hsyncOut = vid_dly_q[ROM_LAT][25];
    assign deOut    = vid_dly_q[ROM_LAT][24];
    assign pixOut   = vid_dly_q[ROM_LAT][23:0];
    assign ovlBit   = romData & hit_dly_q[ROM_LAT];

endmodule

// File: tb/tb_overlay_bit_fetch.sv
// Scoreboard bench for overlay_bit_fetch with a small window (4x2) and a
// 2-cycle ROM model returning address bit 0.
module tb_overlay_bit_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        deIn = 1'b0;
    logic        hsyncIn = 1'b0;
    logic        vsyncIn = 1'b0;
    logic [23:0] pixIn = '0;
    logic [11:0] ovlX = '0;
    logic [11:0] ovlY = '0;
    logic        romData;
    logic [2:0]  romAddr;
    logic        romEn;
    logic        deOut;
    logic        hsyncOut;
    logic        vsyncOut;
    logic [23:0] pixOut;
    logic        ovlBit;

    int errors = 0;
    int checks = 0;

    logic [24:0] exp_pix [$];
    logic [2:0]  exp_addr [$];
    logic [26:0] hist [0:2] = '{default: '0};
    logic        rom_p1 = 1'b0;
    logic        rom_p2 = 1'b0;

    overlay_bit_fetch #(
        .OVL_W(4), .OVL_H(2), .ROM_AW(3), .ROM_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .deIn(deIn), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
        .pixIn(pixIn), .ovlX(ovlX), .ovlY(ovlY), .romData(romData),
        .romAddr(romAddr), .romEn(romEn), .deOut(deOut), .hsyncOut(hsyncOut),
        .vsyncOut(vsyncOut), .pixOut(pixOut), .ovlBit(ovlBit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_p1 <= romAddr[0];
        rom_p2 <= rom_p1;
    end
    assign romData = rom_p2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a ROM request or an active pixel.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {romAddr, romEn, deOut, hsyncOut, vsyncOut, pixOut, ovlBit}, '0);
            exp_pix.delete();
            exp_addr.delete();
            hist = '{default: '0};
        end else begin
            check("video_delay", {vsyncOut, hsyncOut, deOut, pixOut}, hist[2]);
            if (romEn) begin
                if (exp_addr.size() == 0) check("unexpected_romEn", {61'd0, romAddr}, 64'h0);
                else check("romAddr", romAddr, exp_addr.pop_front());
            end
            if (deOut) begin
                if (exp_pix.size() == 0) check("unexpected_pixel", {pixOut, ovlBit}, 64'h0);
                else check("pix_ovlBit", {pixOut, ovlBit}, exp_pix.pop_front());
            end else begin
                check("ovlBit_blank", ovlBit, 1'b0);
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {vsyncIn, hsyncIn, deIn, pixIn};
        end
    end

    task automatic line(input logic [7:0] tag, input int npix, input int first, input int nhits,
                        input int base, input int blank, input int chg_at, input int new_x);
        bit h;
        int a;
        for (int x = 0; x < npix; x++) begin
            h = (x >= first) && (x < first + nhits);
            a = base + x - first;
            @(posedge clk); #1;
            if (x == chg_at) ovlX = 12'(new_x);
            deIn = 1'b1; hsyncIn = 1'b0; vsyncIn = 1'b0;
            pixIn = {tag, 8'h00, 8'(x)};
            exp_pix.push_back({pixIn, h & a[0]});
            if (h) exp_addr.push_back(a[2:0]);
        end
        for (int b = 0; b < blank; b++) begin
            @(posedge clk); #1;
            deIn = 1'b0; pixIn = '0; hsyncIn = (b == 1);
        end
    endtask

    task automatic frame_start(input int ox, input int oy);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            deIn = 1'b0; hsyncIn = 1'b0; pixIn = '0;
            vsyncIn = (c < 2);
            ovlX = 12'(ox); ovlY = 12'(oy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pre-lock: no vsync yet, video only.
        line(8'h10, 8, 0, 0, 0, 4, -1, 0);
        line(8'h11, 8, 0, 0, 0, 4, -1, 0);
        line(8'h12, 8, 0, 0, 0, 4, -1, 0);

        // Basic window at (2,1).
        frame_start(2, 1);
        line(8'h20, 8, 0, 0, 0, 4, -1, 0);
        line(8'h21, 8, 2, 4, 0, 4, -1, 0);
        line(8'h22, 8, 2, 4, 4, 4, -1, 0);
        line(8'h23, 8, 0, 0, 0, 4, -1, 0);

        // Right clip at x=6.
        frame_start(6, 1);
        line(8'h30, 8, 0, 0, 0, 4, -1, 0);
        line(8'h31, 8, 6, 2, 0, 4, -1, 0);
        line(8'h32, 8, 6, 2, 4, 4, -1, 0);
        line(8'h33, 8, 0, 0, 0, 4, -1, 0);

        // Mid-frame position change only applies at next frame start.
        frame_start(2, 1);
        line(8'h40, 8, 0, 0, 0, 4, -1, 0);
        line(8'h41, 8, 2, 4, 0, 4, 3, 0);
        line(8'h42, 8, 2, 4, 4, 4, -1, 0);
        frame_start(0, 1);
        line(8'h43, 8, 0, 0, 0, 4, -1, 0);
        line(8'h44, 8, 0, 4, 0, 4, -1, 0);
        line(8'h45, 8, 0, 4, 4, 4, -1, 0);

        // Reset pulse in the middle of line 1.
        frame_start(2, 1);
        line(8'h50, 8, 0, 0, 0, 4, -1, 0);
        line(8'h51, 3, 2, 4, 0, 0, -1, 0);
        @(posedge clk); #1;
        rst_n = 1'b0; deIn = 1'b0; pixIn = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        line(8'h52, 5, 0, 0, 0, 4, -1, 0);
        line(8'h53, 8, 0, 0, 0, 4, -1, 0);
        frame_start(2, 1);
        line(8'h54, 8, 0, 0, 0, 4, -1, 0);
        line(8'h55, 8, 2, 4, 0, 4, -1, 0);
        line(8'h56, 8, 2, 4, 4, 4, -1, 0);

        // Pixel alignment with pixIn equal to the pixel index.
        frame_start(2, 1);
        line(8'h00, 8, 0, 0, 0, 4, -1, 0);
        line(8'h00, 8, 2, 4, 0, 4, -1, 0);
        line(8'h00, 8, 2, 4, 4, 4, -1, 0);

        repeat (8) @(posedge clk);
        #1;
        check("pix_queue_drained", exp_pix.size(), 0);
        check("addr_queue_drained", exp_addr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
